// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory port, one transaction outstanding.
// Latency: accept N, m_req_valid N+1, response >= N+2; backpressure: holds request until m_req_ready, ports stall outside IDLE.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_req_ready,
    output logic                i_resp_valid,
    output logic [DATA_W-1:0]   i_resp_data,

    input  logic                d_req_valid,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_wen,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_req_ready,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,

    output logic                m_req_valid,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic                m_req_wen,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    input  logic                m_req_ready,
    input  logic                m_resp_valid,
    input  logic [DATA_W-1:0]   m_resp_data,

    output logic                err
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              wen;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    state_t     state_q, state_d;
    req_t       req_q, req_d;
    logic       owner_i_q, owner_i_d;
    logic [3:0] starve_q, starve_d;
    logic       err_q, err_d;

    logic       grant_i, grant_d;
    logic       i_rdy_int, d_rdy_int;
    logic       i_resp_int, d_resp_int;
    logic       m_vld_int;

    // Fetch wins only when alone or once it has waited out STARVE_MAX data wins.
    always_comb begin
        grant_i = i_req_valid && (!d_req_valid || (starve_q == STARVE_LIM));
        grant_d = d_req_valid && !grant_i;
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        owner_i_d  = owner_i_q;
        starve_d   = starve_q;
        err_d      = err_q;
        i_rdy_int  = 1'b0;
        d_rdy_int  = 1'b0;
        i_resp_int = 1'b0;
        d_resp_int = 1'b0;
        m_vld_int  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m_resp_valid) begin
                    err_d = 1'b1;
                end

                if (!i_req_valid || grant_i) begin
                    starve_d = 4'd0;
                end else if (grant_d && (starve_q < STARVE_LIM)) begin
                    starve_d = starve_q + 4'd1;
                end

                if (grant_i) begin
                    i_rdy_int   = 1'b1;
                    req_d.addr  = i_req_addr;
                    req_d.wdata = '0;
                    req_d.wen   = 1'b0;
                    req_d.wstrb = '0;
                    owner_i_d   = 1'b1;
                    state_d     = ISSUE;
                end else if (grant_d) begin
                    d_rdy_int   = 1'b1;
                    req_d.addr  = d_req_addr;
                    req_d.wdata = d_req_wdata;
                    req_d.wen   = d_req_wen;
                    req_d.wstrb = d_req_wstrb;
                    owner_i_d   = 1'b0;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                m_vld_int = 1'b1;
                if (m_req_ready) begin
                    state_d = WAIT;
                    // A response cannot belong to a request only now being accepted.
                    if (m_resp_valid) begin
                        err_d = 1'b1;
                    end
                end
            end

            WAIT: begin
                if (m_resp_valid) begin
                    i_resp_int = owner_i_q;
                    d_resp_int = !owner_i_q;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            owner_i_q <= 1'b1;
            starve_q  <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            owner_i_q <= owner_i_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end

    // Ready/valid are masked by reset so a held request is not handshaken during reset.
    assign i_req_ready  = reset & i_rdy_int;
    assign d_req_ready  = reset & d_rdy_int;
    assign i_resp_valid = reset & i_resp_int;
    assign d_resp_valid = reset & d_resp_int;
    assign m_req_valid  = reset & m_vld_int;

    assign i_resp_data  = m_resp_data;
    assign d_resp_data  = m_resp_data;

    assign m_req_addr   = req_q.addr;
    assign m_req_wdata  = req_q.wdata;
    assign m_req_wen    = req_q.wen;
    assign m_req_wstrb  = req_q.wstrb;

    assign err          = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences, randomized run against a transaction-level model.
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        reset;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_wen;
    logic [31:0] d_req_wdata;
    logic [3:0]  d_req_wstrb;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        m_req_valid;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic        m_req_wen;
    logic [3:0]  m_req_wstrb;
    logic        m_req_ready;
    logic        m_resp_valid;
    logic [31:0] m_resp_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(MAXS)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_addr   (i_req_addr),
        .i_req_ready  (i_req_ready),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_addr   (d_req_addr),
        .d_req_wen    (d_req_wen),
        .d_req_wdata  (d_req_wdata),
        .d_req_wstrb  (d_req_wstrb),
        .d_req_ready  (d_req_ready),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_wen    (m_req_wen),
        .m_req_wstrb  (m_req_wstrb),
        .m_req_ready  (m_req_ready),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid  = 1'b0;
        i_req_addr   = 32'h0;
        d_req_valid  = 1'b0;
        d_req_addr   = 32'h0;
        d_req_wen    = 1'b0;
        d_req_wdata  = 32'h0;
        d_req_wstrb  = 4'h0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = 32'h0;
    endtask

    // Requests held valid during reset must not be handshaken; registered fields must be cleared.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        @(negedge clk);
        #1;
        check("rst_i_rdy", i_req_ready, 0);
        check("rst_d_rdy", d_req_ready, 0);
        check("rst_m_vld", m_req_valid, 0);
        check("rst_err", err, 0);
        check("rst_m_fields", {m_req_addr, m_req_wdata}, 0);
        check("rst_m_wen_strb", {m_req_wen, m_req_wstrb}, 0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        i_v;
        logic        d_v;
        logic        d_wen;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic        exp_i_rdy;
        logic        exp_d_rdy;
        logic        exp_m_vld;
        logic [31:0] exp_m_addr;
        logic        exp_m_wen;
        logic [3:0]  exp_m_wstrb;
        logic [31:0] exp_m_wdata;
    } vec_t;

    vec_t vecs[5];

    // Randomized-phase model state
    logic        busy, sent, own_i, resp_now, win_i, win_d;
    int          cd, starve;
    logic        ip, dp;
    logic [31:0] ia, da, dwd, r_addr, r_wdata;
    logic        dwen, r_wen;
    logic [3:0]  dstrb, r_wstrb;
    string       pattern;
    logic        exp_i;

    initial begin
        reset = 1'b0;
        idle_inputs();

        // First request after reset, one row per arbitration case.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 4'hA, 32'hCAFE0001};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h14, 32'h30, 1'b0, 1'b1, 1'b1, 32'h30, 1'b0, 4'hA, 32'hCAFE0001};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h18, 32'h34, 1'b0, 1'b1, 1'b1, 32'h34, 1'b1, 4'hA, 32'hCAFE0001};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            i_req_valid = vecs[v].i_v;
            i_req_addr  = vecs[v].i_addr;
            d_req_valid = vecs[v].d_v;
            d_req_addr  = vecs[v].d_addr;
            d_req_wen   = vecs[v].d_wen;
            d_req_wdata = 32'hCAFE0001;
            d_req_wstrb = 4'hA;
            #1;
            check($sformatf("vec%0d_i_rdy", v), i_req_ready, vecs[v].exp_i_rdy);
            check($sformatf("vec%0d_d_rdy", v), d_req_ready, vecs[v].exp_d_rdy);
            @(negedge clk);
            idle_inputs();
            #1;
            check($sformatf("vec%0d_m_vld", v), m_req_valid, vecs[v].exp_m_vld);
            check($sformatf("vec%0d_m_addr", v), m_req_addr, vecs[v].exp_m_addr);
            check($sformatf("vec%0d_m_wen_strb", v), {m_req_wen, m_req_wstrb},
                  {vecs[v].exp_m_wen, vecs[v].exp_m_wstrb});
            check($sformatf("vec%0d_m_wdata", v), m_req_wdata, vecs[v].exp_m_wdata);
        end

        // Single fetch, immediate ready, response one cycle later.
        do_reset();
        i_req_valid = 1'b1;
        i_req_addr  = 32'h100;
        #1;
        check("fetch_i_rdy", i_req_ready, 1);
        @(negedge clk);
        i_req_valid = 1'b0;
        m_req_ready = 1'b1;
        #1;
        check("fetch_m_vld", m_req_valid, 1);
        check("fetch_m_addr", m_req_addr, 32'h100);
        check("fetch_m_wen_strb", {m_req_wen, m_req_wstrb}, 0);
        @(negedge clk);
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hDEADBEEF;
        #1;
        check("fetch_m_vld_wait", m_req_valid, 0);
        check("fetch_i_resp_vld", i_resp_valid, 1);
        check("fetch_i_resp_dat", i_resp_data, 32'hDEADBEEF);
        check("fetch_d_resp_vld", d_resp_valid, 0);
        check("fetch_d_resp_dat", d_resp_data, 32'hDEADBEEF);
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        check("fetch_i_resp_drop", i_resp_valid, 0);
        check("fetch_err", err, 0);

        // Both ports held valid: starvation relief order.
        do_reset();
        pattern = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++) begin
            i_req_valid  = 1'b1;
            i_req_addr   = 32'h1000 + 32'(k);
            d_req_valid  = 1'b1;
            d_req_addr   = 32'h2000 + 32'(k);
            m_req_ready  = 1'b1;
            m_resp_valid = 1'b0;
            exp_i = (pattern[k] == "I");
            #1;
            check($sformatf("starve%0d_i_rdy", k), i_req_ready, exp_i);
            check($sformatf("starve%0d_d_rdy", k), d_req_ready, !exp_i);
            @(negedge clk);
            #1;
            check($sformatf("starve%0d_rdy_issue", k), {i_req_ready, d_req_ready}, 0);
            check($sformatf("starve%0d_m_addr", k), m_req_addr,
                  exp_i ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k));
            @(negedge clk);
            m_resp_valid = 1'b1;
            m_resp_data  = 32'h5A000000 + 32'(k);
            #1;
            check($sformatf("starve%0d_resp", k), {i_resp_valid, d_resp_valid}, {exp_i, !exp_i});
            @(negedge clk);
        end
        idle_inputs();

        // Data write with 5 cycles of memory backpressure.
        do_reset();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h40;
        d_req_wen   = 1'b1;
        d_req_wdata = 32'h12345678;
        d_req_wstrb = 4'hF;
        #1;
        check("wr_d_rdy", d_req_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d_req_valid = 1'b0;
            d_req_addr  = $urandom;
            d_req_wdata = $urandom;
            d_req_wen   = 1'b0;
            d_req_wstrb = 4'h0;
            m_req_ready = (c == 5);
            #1;
            check($sformatf("wr_hold%0d", c),
                  {m_req_valid, m_req_addr, m_req_wdata, m_req_wen, m_req_wstrb},
                  {1'b1, 32'h40, 32'h12345678, 1'b1, 4'hF});
        end
        @(negedge clk);
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        #1;
        check("wr_ack", {d_resp_valid, i_resp_valid}, 2'b10);
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        check("wr_ack_drop", d_resp_valid, 0);

        // Stray response while idle sets a sticky error.
        do_reset();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h77;
        #1;
        check("stray_no_resp", {i_resp_valid, d_resp_valid}, 0);
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        check("stray_err", err, 1);
        repeat (3) @(negedge clk);
        #1;
        check("stray_err_sticky", err, 1);

        // Asynchronous reset while waiting for a response.
        do_reset();
        i_req_valid = 1'b1;
        i_req_addr  = 32'h180;
        @(negedge clk);
        i_req_addr  = 32'h200;
        m_req_ready = 1'b1;
        @(negedge clk);
        m_req_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("arst_outputs", {i_req_ready, d_req_ready, m_req_valid, i_resp_valid, d_resp_valid, err}, 0);
        check("arst_m_addr", m_req_addr, 0);
        @(negedge clk);
        #1;
        check("arst_hold_rdy", i_req_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_first_accept", i_req_ready, 1);
        @(negedge clk);
        i_req_valid = 1'b0;
        m_req_ready = 1'b1;
        #1;
        check("arst_new_addr", {m_req_valid, m_req_addr}, {1'b1, 32'h200});
        @(negedge clk);
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hA5A5A5A5;
        #1;
        check("arst_new_resp", {i_resp_valid, i_resp_data}, {1'b1, 32'hA5A5A5A5});
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        check("arst_no_err", err, 0);
        @(negedge clk);
        m_resp_valid = 1'b1;
        #1;
        check("arst_old_resp_ignored", {i_resp_valid, d_resp_valid}, 0);
        @(negedge clk);
        m_resp_valid = 1'b0;
        #1;
        check("arst_old_resp_err", err, 1);

        // Response coinciding with request acceptance.
        do_reset();
        d_req_valid = 1'b1;
        d_req_addr  = 32'h88;
        #1;
        check("coin_d_rdy", d_req_ready, 1);
        @(negedge clk);
        d_req_valid  = 1'b0;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        #1;
        check("coin_no_resp", {i_resp_valid, d_resp_valid}, 0);
        @(negedge clk);
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        #1;
        check("coin_err", err, 1);
        check("coin_wait", {m_req_valid, d_resp_valid}, 0);
        @(negedge clk);
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h0BADF00D;
        #1;
        check("coin_complete", {d_resp_valid, d_resp_data}, {1'b1, 32'h0BADF00D});
        @(negedge clk);
        m_resp_valid = 1'b0;
        i_req_valid  = 1'b1;
        #1;
        check("coin_idle_again", i_req_ready, 1);

        // Randomized traffic against a transaction-level model.
        do_reset();
        busy = 0; sent = 0; own_i = 1; cd = 0; starve = 0;
        ip = 0; dp = 0; ia = 0; da = 0; dwd = 0; dwen = 0; dstrb = 0;
        r_addr = 0; r_wdata = 0; r_wen = 0; r_wstrb = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) @(negedge clk);
            if (!ip && ($urandom_range(0, 9) < 6)) begin
                ip = 1; ia = $urandom;
            end
            if (!dp && ($urandom_range(0, 9) < 6)) begin
                dp = 1; da = $urandom; dwd = $urandom;
                dwen = 1'($urandom_range(0, 1)); dstrb = 4'($urandom_range(0, 15));
            end
            i_req_valid  = ip;
            i_req_addr   = ip ? ia : $urandom;
            d_req_valid  = dp;
            d_req_addr   = dp ? da : $urandom;
            d_req_wdata  = dp ? dwd : $urandom;
            d_req_wen    = dp ? dwen : 1'b0;
            d_req_wstrb  = dp ? dstrb : 4'h0;
            m_req_ready  = 1'($urandom_range(0, 1));
            resp_now     = busy && sent && (cd == 0);
            m_resp_valid = resp_now;
            m_resp_data  = $urandom;
            #1;
            win_i = !busy && ip && (!dp || (starve == MAXS));
            win_d = !busy && dp && !win_i;
            check("rnd_i_rdy", i_req_ready, win_i);
            check("rnd_d_rdy", d_req_ready, win_d);
            check("rnd_m_vld", m_req_valid, busy && !sent);
            if (busy && !sent)
                check("rnd_m_fields", {m_req_addr, m_req_wdata, m_req_wen, m_req_wstrb},
                      {r_addr, r_wdata, r_wen, r_wstrb});
            check("rnd_resp_vld", {i_resp_valid, d_resp_valid}, {resp_now && own_i, resp_now && !own_i});
            if (resp_now)
                check("rnd_resp_dat", {i_resp_data, d_resp_data}, {m_resp_data, m_resp_data});
            check("rnd_err", err, 0);

            if (!busy) begin
                if (!ip || win_i) starve = 0;
                else if (win_d && starve < MAXS) starve++;
                if (win_i) begin
                    busy = 1; sent = 0; own_i = 1;
                    r_addr = ia; r_wdata = 0; r_wen = 0; r_wstrb = 0;
                    ip = 0;
                end else if (win_d) begin
                    busy = 1; sent = 0; own_i = 0;
                    r_addr = da; r_wdata = dwd; r_wen = dwen; r_wstrb = dstrb;
                    dp = 0;
                end
            end else if (!sent) begin
                if (m_req_ready) begin
                    sent = 1;
                    cd = $urandom_range(0, 3);
                end
            end else if (resp_now) begin
                busy = 0;
                sent = 0;
            end else begin
                cd--;
            end
        end

        @(negedge clk);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 32, address width.
  DATA_W, 32, data width; DATA_W/8 strobe bits.
  STARVE_MAX, 4, consecutive data-port wins tolerated while the instruction port waits; legal range 1..15.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all state on rising edge.
  reset  in  1  asynchronous, active-low reset.
  i_req_valid  in  1  fetch request.
  i_req_addr  in  ADDR_W  fetch address.
  i_req_ready  out  1  fetch request accepted this cycle.
  i_resp_valid  out  1  fetch data valid.
  i_resp_data  out  DATA_W  fetch data.
  d_req_valid  in  1  data request.
  d_req_addr  in  ADDR_W  data address.
  d_req_wen  in  1  1 = write, 0 = read.
  d_req_wdata  in  DATA_W  write data.
  d_req_wstrb  in  DATA_W/8  byte enables.
  d_req_ready  out  1  data request accepted this cycle.
  d_resp_valid  out  1  read data or write acknowledge.
  d_resp_data  out  DATA_W  read data.
  m_req_valid  out  1  shared-memory request.
  m_req_addr / m_req_wdata / m_req_wen / m_req_wstrb  out  as d_*  registered request fields.
  m_req_ready  in  1  memory accepts request.
  m_resp_valid  in  1  memory response; exactly one per accepted request, reads and writes.
  m_resp_data  in  DATA_W  response data.
  err  out  1  sticky protocol-error flag.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE, WAIT. At most one transaction is outstanding.
REQ-004 IDLE behaviour:
  - If any x_req_valid is high, pick a winner per REQ-005.
  - Assert the winner's x_req_ready combinationally in the same cycle.
  - Capture the winner's fields and an owner bit; go to ISSUE.
  - Fetch requests SHALL register with wen=0 and wstrb=0.
REQ-005 Arbitration:
  - The data port wins by default.
  - The instruction port wins when only it is valid, or when the starve counter equals STARVE_MAX.
REQ-006 Starve counter (4 bits):
  - Increments when the data port wins while i_req_valid is high.
  - Clears when the instruction port wins, or when i_req_valid is low in IDLE.
  - Saturates at STARVE_MAX.
REQ-007 ISSUE behaviour:
  - m_req_valid=1 with the registered fields.
  - Fields SHALL stay stable until m_req_ready.
  - On m_req_ready go to WAIT; otherwise hold.
REQ-008 WAIT behaviour:
  - On m_resp_valid, raise the owner's x_resp_valid for that cycle only.
  - Drive x_resp_data = m_resp_data combinationally; return to IDLE.
  - The non-owner's resp_valid SHALL stay 0.
REQ-009 x_req_ready SHALL be 0 outside IDLE; m_req_valid SHALL be 0 outside ISSUE.
REQ-010 Timing:
  - Minimum latency: accept in cycle N, m_req_valid in N+1, response no earlier than N+2.
  - Peak throughput: one transaction per 3 cycles.
REQ-011 Simultaneous m_req_ready and m_resp_valid in ISSUE: accept the request and ignore the response; this SHALL set err.
REQ-012 m_resp_valid in IDLE, or in ISSUE per REQ-011, SHALL set err. Once set, err holds until reset.
REQ-013 i_resp_data and d_resp_data SHALL both carry m_resp_data; only the valid bits are gated.

Reset
REQ-014 Assertion (reset=0) SHALL asynchronously force:
  - state=IDLE, starve counter=0, err=0.
  - owner=instruction; all registered m_req fields=0.
  - All valid and ready outputs=0 while reset is low.
REQ-015 Reset mid-transaction SHALL abandon the outstanding request without any response. A later stray m_resp_valid SHALL set err per REQ-012.
REQ-016 After deassertion, the first request SHALL be accepted in the first cycle IDLE observes a valid.

Verification
REQ-017 Single fetch, addr=0x100, m_req_ready=1 immediately, m_resp 1 cycle later with 0xDEADBEEF -> i_resp_valid for one cycle, data 0xDEADBEEF, 3 cycles total, d_resp_valid=0.
REQ-018 Both ports held valid continuously, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I...
REQ-019 Data write addr=0x40, wdata=0x12345678, wstrb=0xF, m_req_ready low 5 cycles -> m_req fields stable all 5 cycles; d_resp_valid pulses on the ack.
REQ-020 Stray m_resp_valid in IDLE -> err=1 and stays 1; no x_resp_valid raised.
REQ-021 reset=0 asynchronously while in WAIT -> all outputs 0 immediately; after release a new fetch completes normally; the old response, if delivered, sets err.
REQ-022 m_resp_valid and m_req_ready in the same ISSUE cycle -> err=1, FSM goes to WAIT, the next m_resp_valid completes the transaction.
